// File: rtl/tdrf_dual_reader.sv
// Dual-port time-domain register-file reader: launches one read pulse and measures the
// return delay on two selected lines, with per-port timeout and a drain phase.
module tdrf_dual_reader #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       a_sel_i,
    input  logic [2:0]       b_sel_i,
    output logic [2:0]       rd_sel_a_o,
    output logic [2:0]       rd_sel_b_o,
    output logic             launch_o,
    input  logic [7:0]       rf_ret_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [CNT_W-1:0] a_val_o,
    output logic [CNT_W-1:0] b_val_o,
    output logic             a_to_o,
    output logic             b_to_o
);

    typedef enum logic [2:0] {StIdle, StLaunch, StMeasure, StResp, StDrain} state_e;

    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntMax     = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic [CNT_W-1:0] a_val_q, a_val_d, b_val_q, b_val_d;
    logic             a_to_q, a_to_d, b_to_q, b_to_d;
    logic             a_cap_q, a_cap_d, b_cap_q, b_cap_d;
    logic [7:0]       s1_q, s2_q, s3_q;

    logic [7:0] rise;
    logic       accept, rise_a, rise_b, a_done, b_done, at_timeout;

    assign rise       = s2_q & ~s3_q;
    assign rise_a     = rise[sel_a_q];
    assign rise_b     = rise[sel_b_q];
    assign a_done     = a_cap_q | rise_a;
    assign b_done     = b_cap_q | rise_b;
    assign at_timeout = (cnt_q == TimeoutVal);
    assign accept     = (state_q == StIdle) && req_valid_i;

    // Return lines are asynchronous; s3 keeps history so only rising edges count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= rf_ret_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (req_valid_i) state_d = StLaunch;
            StLaunch:  state_d = StMeasure;
            StMeasure: if ((a_done && b_done) || at_timeout) state_d = StResp;
            StResp:    if (rsp_ready_i) state_d = StDrain;
            StDrain:   if (s2_q == 8'h00) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == StIdle);
        launch_o    = (state_q == StLaunch);
        rsp_valid_o = (state_q == StResp);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            sel_a_q <= '0;
            sel_b_q <= '0;
            a_val_q <= '0;
            b_val_q <= '0;
            a_to_q  <= 1'b0;
            b_to_q  <= 1'b0;
            a_cap_q <= 1'b0;
            b_cap_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            a_val_q <= a_val_d;
            b_val_q <= b_val_d;
            a_to_q  <= a_to_d;
            b_to_q  <= b_to_d;
            a_cap_q <= a_cap_d;
            b_cap_q <= b_cap_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        sel_a_d = sel_a_q;
        sel_b_d = sel_b_q;
        a_val_d = a_val_q;
        b_val_d = b_val_q;
        a_to_d  = a_to_q;
        b_to_d  = b_to_q;
        a_cap_d = a_cap_q;
        b_cap_d = b_cap_q;
        if (accept) begin
            sel_a_d = a_sel_i;
            sel_b_d = b_sel_i;
            cnt_d   = '0;
            a_val_d = '0;
            b_val_d = '0;
            a_to_d  = 1'b0;
            b_to_d  = 1'b0;
            a_cap_d = 1'b0;
            b_cap_d = 1'b0;
        end else if (state_q == StMeasure) begin
            if (cnt_q != CntMax) cnt_d = cnt_q + CNT_W'(1);
            if (!a_cap_q && rise_a) begin
                a_val_d = cnt_q;
                a_cap_d = 1'b1;
            end
            if (!b_cap_q && rise_b) begin
                b_val_d = cnt_q;
                b_cap_d = 1'b1;
            end
            if (at_timeout && !a_done) begin
                a_val_d = TimeoutVal;
                a_to_d  = 1'b1;
            end
            if (at_timeout && !b_done) begin
                b_val_d = TimeoutVal;
                b_to_d  = 1'b1;
            end
        end
    end

    assign rd_sel_a_o = sel_a_q;
    assign rd_sel_b_o = sel_b_q;
    assign a_val_o    = a_val_q;
    assign b_val_o    = b_val_q;
    assign a_to_o     = a_to_q;
    assign b_to_o     = b_to_q;

endmodule

// File: tb/tb_tdrf_dual_reader.sv
// Scoreboard bench for tdrf_dual_reader: expected responses are queued when a read is
// issued and compared when the response appears.
module tb_tdrf_dual_reader;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 255;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [2:0]       a_sel = '0, b_sel = '0;
    logic [2:0]       rd_sel_a, rd_sel_b;
    logic             launch;
    logic [7:0]       rf_ret = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [CNT_W-1:0] a_val, b_val;
    logic             a_to, b_to;

    typedef struct {
        int a_val;
        int b_val;
        bit a_to;
        bit b_to;
        int meas;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   accepted = 0;
    int   launch_cnt = 0;

    always #5 clk = ~clk;

    tdrf_dual_reader #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .a_sel_i    (a_sel),
        .b_sel_i    (b_sel),
        .rd_sel_a_o (rd_sel_a),
        .rd_sel_b_o (rd_sel_b),
        .launch_o   (launch),
        .rf_ret_i   (rf_ret),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .a_val_o    (a_val),
        .b_val_o    (b_val),
        .a_to_o     (a_to),
        .b_to_o     (b_to)
    );

    always @(negedge clk) if (launch) launch_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Earliest MEASURE cycle in which line sel is driven high (-1 if never).
    function automatic int line_k(logic [2:0] sel, logic [2:0] a, logic [2:0] b, int ka, int kb);
        int k = -1;
        if (a == sel && ka >= 0) k = ka;
        if (b == sel && kb >= 0 && (k < 0 || kb < k)) k = kb;
        return k;
    endfunction

    // Capture lands two cycles after the rise (synchronizer), unless past the timeout.
    function automatic int cap_k(int k);
        return (k >= 0 && k + 2 <= TIMEOUT) ? k + 2 : -1;
    endfunction

    task automatic push_exp(logic [2:0] a, logic [2:0] b, int ka, int kb);
        exp_t e;
        int ca, cb;
        ca = cap_k(line_k(a, a, b, ka, kb));
        cb = cap_k(line_k(b, a, b, ka, kb));
        e.a_val = (ca >= 0) ? ca : TIMEOUT;
        e.b_val = (cb >= 0) ? cb : TIMEOUT;
        e.a_to  = (ca < 0);
        e.b_to  = (cb < 0);
        e.meas  = ((ca >= 0 && cb >= 0) ? ((ca > cb) ? ca : cb) : TIMEOUT) + 1;
        exp_q.push_back(e);
    endtask

    task automatic issue(logic [2:0] a, logic [2:0] b);
        int n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL issue_wait: req_ready=%0b after %0d cycles, required 1", req_ready, n);
        end
        req_valid = 1'b1;
        a_sel = a;
        b_sel = b;
        tick();
        req_valid = 1'b0;
        accepted++;
    endtask

    // Runs MEASURE from k=0, raising lines at their cycles; returns MEASURE cycle count.
    task automatic measure(logic [2:0] a, logic [2:0] b, int ka, int kb, output int cyc);
        tick();
        cyc = 0;
        while (!rsp_valid && cyc < 400) begin
            if (cyc == ka) rf_ret[a] = 1'b1;
            if (cyc == kb) rf_ret[b] = 1'b1;
            tick();
            cyc++;
        end
        if (cyc >= 400) begin
            n_cmp++;
            n_fail++;
            $display("FAIL measure_wait: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, cyc);
        end
    endtask

    task automatic finish_rsp();
        int n = 0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        rf_ret = '0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_wait: req_ready=%0b after %0d cycles, required 1", req_ready, n);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_cmp++;
        if ({req_ready, launch, rsp_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready/launch/rsp=%b, required 100",
                     {req_ready, launch, rsp_valid});
        end
        n_cmp++;
        if ({rd_sel_a, rd_sel_b, a_val, b_val, a_to, b_to} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: sel=%0d/%0d val=%0d/%0d to=%b%b, required all 0",
                     rd_sel_a, rd_sel_b, a_val, b_val, a_to, b_to);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_reads();
        logic [2:0] ta[4] = '{3'd2, 3'd7, 3'd1, 3'd0};
        logic [2:0] tb[4] = '{3'd5, 3'd7, 3'd4, 3'd6};
        int         tka[4] = '{3, 0, 10, 253};
        int         tkb[4] = '{6, -1, -1, 254};
        exp_t e;
        int   cyc;
        for (int i = 0; i < 4; i++) begin
            push_exp(ta[i], tb[i], tka[i], tkb[i]);
            issue(ta[i], tb[i]);
            n_cmp++;
            if (rd_sel_a !== ta[i] || rd_sel_b !== tb[i]) begin
                n_fail++;
                $display("FAIL sel_latch[%0d]: got %0d/%0d, required %0d/%0d",
                         i, rd_sel_a, rd_sel_b, ta[i], tb[i]);
            end
            measure(ta[i], tb[i], tka[i], tkb[i], cyc);
            e = exp_q.pop_front();
            n_cmp++;
            if (a_val !== CNT_W'(e.a_val) || a_to !== e.a_to) begin
                n_fail++;
                $display("FAIL read_a[%0d]: val=%0d to=%b, required val=%0d to=%b",
                         i, a_val, a_to, e.a_val, e.a_to);
            end
            n_cmp++;
            if (b_val !== CNT_W'(e.b_val) || b_to !== e.b_to) begin
                n_fail++;
                $display("FAIL read_b[%0d]: val=%0d to=%b, required val=%0d to=%b",
                         i, b_val, b_to, e.b_val, e.b_to);
            end
            n_cmp++;
            if (cyc !== e.meas) begin
                n_fail++;
                $display("FAIL resp_latency[%0d]: %0d measure cycles, required %0d",
                         i, cyc, e.meas);
            end
            finish_rsp();
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   cyc;
        push_exp(3'd2, 3'd3, 1, 2);
        issue(3'd2, 3'd3);
        measure(3'd2, 3'd3, 1, 2, cyc);
        e = exp_q.pop_front();
        req_valid = 1'b1;
        a_sel = 3'd6;
        b_sel = 3'd6;
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (!rsp_valid || req_ready || a_val !== CNT_W'(e.a_val) || b_val !== CNT_W'(e.b_val)
                || a_to !== e.a_to || b_to !== e.b_to) begin
                n_fail++;
                $display("FAIL hold[%0d]: rsp=%b rdy=%b val=%0d/%0d to=%b%b, required 1 0 %0d/%0d %b%b",
                         i, rsp_valid, req_ready, a_val, b_val, a_to, b_to,
                         e.a_val, e.b_val, e.a_to, e.b_to);
            end
            tick();
        end
        req_valid = 1'b0;
        rf_ret = 8'h04;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (req_ready || rsp_valid) begin
                n_fail++;
                $display("FAIL drain_hold[%0d]: rdy=%b rsp=%b, required 0 0", i, req_ready, rsp_valid);
            end
            tick();
        end
        rf_ret = '0;
        tick();
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_early: req_ready=%b one cycle after fall, required 0", req_ready);
        end
        tick();
        tick();
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_exit: req_ready=%b three edges after fall, required 1", req_ready);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   cyc;
        issue(3'd6, 3'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 1) rf_ret[6] = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (launch !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: launch=%b rsp=%b rdy=%b, required 0 0 1",
                     launch, rsp_valid, req_ready);
        end
        rf_ret = '0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (req_ready !== 1'b1 || a_val !== '0) begin
            n_fail++;
            $display("FAIL post_reset: rdy=%b a_val=%0d, required 1 0", req_ready, a_val);
        end
        push_exp(3'd6, 3'd0, 5, 8);
        issue(3'd6, 3'd0);
        measure(3'd6, 3'd0, 5, 8, cyc);
        e = exp_q.pop_front();
        n_cmp++;
        if (a_val !== CNT_W'(e.a_val) || b_val !== CNT_W'(e.b_val) || a_to || b_to
            || cyc !== e.meas) begin
            n_fail++;
            $display("FAIL reset_reread: val=%0d/%0d to=%b%b cyc=%0d, required %0d/%0d 00 %0d",
                     a_val, b_val, a_to, b_to, cyc, e.a_val, e.b_val, e.meas);
        end
        finish_rsp();
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        int         cyc, ka, kb;
        logic [2:0] a, b;
        for (int i = 0; i < 8; i++) begin
            a  = 3'($urandom_range(0, 7));
            b  = 3'($urandom_range(0, 7));
            ka = $urandom_range(0, 20);
            kb = $urandom_range(0, 20);
            push_exp(a, b, ka, kb);
            issue(a, b);
            measure(a, b, ka, kb, cyc);
            e = exp_q.pop_front();
            n_cmp++;
            if (a_val !== CNT_W'(e.a_val) || b_val !== CNT_W'(e.b_val) || a_to !== e.a_to
                || b_to !== e.b_to || cyc !== e.meas) begin
                n_fail++;
                $display("FAIL b2b[%0d] sel=%0d/%0d k=%0d/%0d: val=%0d/%0d to=%b%b cyc=%0d, required %0d/%0d %b%b %0d",
                         i, a, b, ka, kb, a_val, b_val, a_to, b_to, cyc,
                         e.a_val, e.b_val, e.a_to, e.b_to, e.meas);
            end
            finish_rsp();
        end
        tick();
        n_cmp++;
        if (launch_cnt !== accepted) begin
            n_fail++;
            $display("FAIL launch_count: %0d launch cycles, required %0d", launch_cnt, accepted);
        end
    endtask

    initial begin
        test_reset();
        test_basic_reads();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tdrf_dual_reader.md
TDRF_DUAL_READER -- requirements
Module: tdrf_dual_reader

Interface
REQ-001 Parameter CNT_W, default 8: width of measured delay values and internal counter.
REQ-002 Parameter TIMEOUT, default 255: last MEASURE cycle index; must be at least 1 and at most 2^CNT_W-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  read request present.
REQ-006 req_ready  output  1  block accepts request this cycle.
REQ-007 a_sel, b_sel  input  3 each  register indices for read ports A and B; sampled on request acceptance.
REQ-008 rd_sel_a, rd_sel_b  output  3 each  registered selects to the 2x8 read decoder.
REQ-009 launch  output  1  single-cycle read pulse into the decoder data input.
REQ-010 rf_ret  input  8  asynchronous delayed-pulse returns from the 8 register cells.
REQ-011 rsp_valid  output  1  result available.
REQ-012 rsp_ready  input  1  consumer takes result.
REQ-013 a_val, b_val  output  CNT_W each  measured delays for ports A and B.
REQ-014 a_to, b_to  output  1 each  timeout flags for ports A and B.

Function
REQ-015 The FSM shall have the states IDLE, LAUNCH, MEASURE, RESP and DRAIN.
REQ-016 req_ready shall be 1 only in IDLE; a request is accepted in the cycle where req_valid and req_ready are both 1.
REQ-017 On acceptance, a_sel and b_sel shall be latched into rd_sel_a and rd_sel_b, cnt shall be cleared to 0, and the FSM shall go to LAUNCH.
REQ-018 rd_sel_a and rd_sel_b shall hold their latched values until the next accepted request.
REQ-019 launch shall be 1 for exactly the single LAUNCH cycle and 0 in every other state; LAUNCH always goes to MEASURE.
REQ-020 Each rf_ret bit shall pass through a two-flop synchronizer (s1, s2) plus a history flop s3; a rise is s2 & ~s3.
REQ-021 The synchronizer and history flops shall clock in every state.
REQ-022 In MEASURE, cnt is the MEASURE cycle index k (first MEASURE cycle is k=0) and increments by 1 each cycle.
REQ-023 A rise on rf_ret[rd_sel_a] in MEASURE cycle k while A is not yet captured shall set a_val=k and mark A captured; B behaves the same on rf_ret[rd_sel_b].
REQ-024 Once a port is captured, later rises on its line shall be ignored.
REQ-025 If rd_sel_a equals rd_sel_b, both ports shall capture in the same cycle with equal values.
REQ-026 Rises on unselected lines shall be ignored.
REQ-027 MEASURE shall exit to RESP in the cycle both ports are captured, including a capture made in that same cycle.
REQ-028 MEASURE shall also exit to RESP at k=TIMEOUT. Each port uncaptured at that point gets val=TIMEOUT and its to flag set to 1.
REQ-029 A capture at k=TIMEOUT shall count as a capture, with to=0.
REQ-030 In RESP, rsp_valid shall be 1 and a_val, b_val, a_to and b_to shall stay stable until rsp_ready=1; then the FSM goes to DRAIN.
REQ-031 rsp_valid shall be 0 outside RESP.
REQ-032 DRAIN shall go to IDLE in the first cycle in which all 8 s2 bits are 0; this guarantees lines are low before the next launch.
REQ-033 cnt shall saturate and never wrap.

Reset
REQ-034 While rst_n=0, the FSM shall be in IDLE. cnt, rd_sel_a, rd_sel_b, a_val, b_val, a_to, b_to, launch, rsp_valid, s1, s2 and s3 shall be 0, and req_ready shall be 1.
REQ-035 Reset asserted mid-operation (LAUNCH, MEASURE, RESP or DRAIN) shall abort immediately with no response issued; the first cycle after deassertion is IDLE.

Verification
REQ-036 Basic read: request a_sel=2, b_sel=5; rf_ret[2] rises during MEASURE k=3 and rf_ret[5] rises during k=6 -> rsp_valid with a_val=5, b_val=8, a_to=0, b_to=0.
REQ-037 Same index: a_sel=b_sel=7; rf_ret[7] rises during k=0 -> a_val=b_val=2, both to=0, and RESP is entered one cycle after the capture.
REQ-038 Timeout: a_sel=1, b_sel=4, TIMEOUT=255; only rf_ret[1] rises, during k=10 -> a_val=12, a_to=0, b_val=255, b_to=1, and RESP is entered after k=255.
REQ-039 Backpressure and drain: hold rsp_ready=0 for 20 cycles -> outputs stable and req_ready=0. Then rsp_ready=1 while rf_ret[2] is held high -> FSM stays in DRAIN until 2 cycles after rf_ret[2] falls, then req_ready=1.
REQ-040 Reset mid-MEASURE: pull rst_n low at k=4 -> launch=0 and rsp_valid=0 at once. After release: req_ready=1, and a new request gets correct values with no stale capture.
REQ-041 Handshake: launch shall be high exactly 1 cycle per accepted request, and req_valid while not in IDLE shall not be accepted.
